datamem_arbiter: RTL and testbench
==================================

Name: datamem_arbiter

Overview:
- Shares the single-port 16-bit data memory between two requesters: port 0 is the processor load/store unit and port 1 is the host/debug loader.
- Runs a small FSM that arbitrates round-robin, issues one memory access at a time, waits a configurable read latency and returns a one-cycle acknowledge with read data.
- Sits between the processor core and the datamem array. The core stalls its load/store state until it sees ack.

Parameters:
- AW, 16, address width in bits
- DW, 16, data width in bits
- RDLAT, 1, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..7

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- req0  in  1  port 0 request; held high with fields stable until ack0
- we0  in  1  port 0 write enable (1 = store, 0 = load)
- addr0  in  AW  port 0 address
- wdata0  in  DW  port 0 write data
- ack0  out  1  one-cycle completion pulse for port 0
- req1, we1, addr1, wdata1, ack1  same as port 0, for port 1
- rdata  out  DW  read data of the most recent completed load; valid in the ack cycle and held until the next load completes
- busy  out  1  high in every state except IDLE
- owner  out  1  port being served; meaningful while busy
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid RDLAT cycles after the mem_en cycle

Behaviour:
- Reset value of every output is 0: ack0, ack1, rdata, busy, owner, mem_en, mem_we, mem_addr, mem_wdata. State returns to IDLE. The last-served pointer resets to 1, so port 0 wins the first tie.
- Reset mid-access aborts immediately: mem_en drops asynchronously, no ack is produced, and the pending access is lost.
- All outputs are registered. No combinational path runs from req/addr to mem_*.
- FSM states are IDLE, ISSUE, WAIT and DONE.
- IDLE:
  - If exactly one req is high, that port wins.
  - If both are high, the port not equal to the last-served pointer wins.
  - On a win, latch owner, we, addr and wdata, then go to ISSUE.
  - If no req is high, stay in IDLE.
- ISSUE (1 cycle):
  - mem_en=1; mem_we, mem_addr and mem_wdata come from the latched values.
  - Write: go to DONE.
  - Read: load the latency counter with RDLAT-1 and go to WAIT.
- WAIT:
  - mem_en=0. Decrement the counter each cycle.
  - In the cycle the counter reads 0, capture mem_rdata into rdata and go to DONE.
  - With RDLAT=1, WAIT lasts exactly one cycle.
- DONE (1 cycle):
  - ack[owner]=1.
  - Set last-served pointer = owner, then go to IDLE.
  - rdata is unchanged on a write.
- Latency:
  - Write: request sampled in IDLE, ack 2 cycles later.
  - Read: ack RDLAT+2 cycles after the IDLE sample.
  - Minimum spacing between grants is 3 cycles for a write and RDLAT+3 for a read.
- A requester deasserts req in the cycle after its ack. A req still high in IDLE after its ack is a new request.
- Requests arriving while busy wait; nothing is queued beyond the req level.
- A req dropped before ack is a protocol violation. The access still completes and ack still pulses.
- Field changes while req is high and not yet granted are allowed; values are sampled only in the IDLE grant cycle.
- ack0 and ack1 are never high together. mem_en is high for exactly one cycle per grant.
- Address arithmetic: none. addr is passed through unmodified; the full 2^AW space is reachable, and 16'hFFFF has no special treatment.

Test Plan:
- Single read, RDLAT=1: port 0 loads addr 16'h0010 with memory holding 16'hBEEF → mem_en one cycle with mem_we=0 and mem_addr=16'h0010; ack0 pulses 3 cycles after the IDLE sample with rdata=16'hBEEF; ack1 stays 0.
- Single write: port 1 stores 16'h1234 to 16'hFFFF → one mem_en cycle with mem_we=1, mem_addr=16'hFFFF, mem_wdata=16'h1234; ack1 pulses 2 cycles after the IDLE sample; rdata unchanged.
- Simultaneous requests: req0 and req1 rise in the same cycle after reset and stay up for 4 accesses → grant order 0,1,0,1; no cycle has both acks high.
- Latency sweep: RDLAT=1, 3 and 7 with back-to-back port 0 reads → ack spacing equals RDLAT+3 cycles; rdata matches the memory model value each time.
- Reset during WAIT: RDLAT=4, port 1 read, reset driven low in the second WAIT cycle → all outputs are 0 immediately; no ack1 occurs; after release, a port 0 request is granted first because the pointer has reset.
- Held request: port 0 keeps req0 high for 2 cycles after ack0 with req1 idle → a second access to the same address is issued and ack0 pulses again.

Source files
------------

// File: rtl/datamem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the single-port datamem array.
// Requester handshake: reqN is raised with weN/addrN/wdataN and held until ackN, a one-cycle completion pulse; fields are sampled only when the arbiter grants.
interface datamem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          ack0;
  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          ack1;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          owner;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    dbg_state;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    output ack0, ack1, rdata, busy, owner, mem_en, mem_we, mem_addr, mem_wdata, dbg_state
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    input  ack0, ack1, rdata, busy, owner, mem_en, mem_we, mem_addr, mem_wdata, dbg_state
  );
endinterface

// File: rtl/datamem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the load/store unit (port 0)
// and the host loader (port 1); one access at a time, registered outputs, RDLAT-cycle read wait.
module datamem_arbiter #(
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int RDLAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  datamem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state;
  state_t        state_n;
  logic          last;
  logic [2:0]    cnt;
  logic          gnt;
  logic          gnt_we;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] gnt_wdata;

  assign bus.dbg_state = state;

  // On a tie the port that was not served last wins.
  always_comb begin
    gnt       = (bus.req0 && bus.req1) ? ~last : bus.req1;
    gnt_we    = gnt ? bus.we1    : bus.we0;
    gnt_addr  = gnt ? bus.addr1  : bus.addr0;
    gnt_wdata = gnt ? bus.wdata1 : bus.wdata0;
    state_n   = state;
    case (state)
      IDLE:    if (bus.req0 || bus.req1) state_n = ISSUE;
      ISSUE:   state_n = bus.mem_we ? DONE : WAIT;
      WAIT:    if (cnt == 3'd0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Outputs are loaded from the next state so every one of them leaves a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.ack0      <= 1'b0;
      bus.ack1      <= 1'b0;
      bus.rdata     <= '0;
      bus.busy      <= 1'b0;
      bus.owner     <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      last          <= 1'b1;
      cnt           <= 3'd0;
    end else begin
      bus.mem_en <= (state_n == ISSUE);
      bus.busy   <= (state_n != IDLE);
      bus.ack0   <= (state_n == DONE) && !bus.owner;
      bus.ack1   <= (state_n == DONE) &&  bus.owner;
      if (state == IDLE && state_n == ISSUE) begin
        bus.owner     <= gnt;
        bus.mem_we    <= gnt_we;
        bus.mem_addr  <= gnt_addr;
        bus.mem_wdata <= gnt_wdata;
      end
      if (state == ISSUE)     cnt <= 3'(RDLAT - 1);
      else if (state == WAIT) cnt <= cnt - 3'd1;
      if (state == WAIT && cnt == 3'd0) bus.rdata <= bus.mem_rdata;
      if (state == DONE) last <= bus.owner;
    end
  end

endmodule

// File: tb/tb_datamem_arbiter.sv
// Bench for datamem_arbiter: four instances with RDLAT 1/3/4/7, a behavioural memory, and a
// request-level model (round-robin pointer, access latencies, last load value) for expectations.
module tb_datamem_arbiter;

  localparam int NDUT = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int lat_of [NDUT] = '{1, 3, 4, 7};

  logic        req0 [NDUT], we0 [NDUT], req1 [NDUT], we1 [NDUT];
  logic [15:0] addr0 [NDUT], wdata0 [NDUT], addr1 [NDUT], wdata1 [NDUT];
  logic        ack0 [NDUT], ack1 [NDUT], busy [NDUT], owner [NDUT], mem_en [NDUT], mem_we [NDUT];
  logic [15:0] rdata [NDUT], mem_addr [NDUT], mem_wdata [NDUT];
  logic [1:0]  dbg_state [NDUT];

  logic [15:0] mem_wr [logic [17:0]];
  bit          last_srv [NDUT];
  logic [15:0] last_rd [NDUT];

  function automatic logic [15:0] mem_read(input int d, input logic [15:0] a);
    logic [17:0] k;
    k = {d[1:0], a};
    if (mem_wr.exists(k)) return mem_wr[k];
    return (a * 16'd7) ^ 16'h5A3C ^ {14'd0, d[1:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 4 : 7;
    datamem_arbiter_if #(.AW(16), .DW(16)) bus ();
    logic [15:0] pipe [LAT];

    assign bus.req0   = req0[g];
    assign bus.we0    = we0[g];
    assign bus.addr0  = addr0[g];
    assign bus.wdata0 = wdata0[g];
    assign bus.req1   = req1[g];
    assign bus.we1    = we1[g];
    assign bus.addr1  = addr1[g];
    assign bus.wdata1 = wdata1[g];
    assign ack0[g]      = bus.ack0;
    assign ack1[g]      = bus.ack1;
    assign rdata[g]     = bus.rdata;
    assign busy[g]      = bus.busy;
    assign owner[g]     = bus.owner;
    assign mem_en[g]    = bus.mem_en;
    assign mem_we[g]    = bus.mem_we;
    assign mem_addr[g]  = bus.mem_addr;
    assign mem_wdata[g] = bus.mem_wdata;
    assign dbg_state[g] = bus.dbg_state;

    datamem_arbiter #(.AW(16), .DW(16), .RDLAT(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );

    // Memory read data appears LAT cycles after the strobe; poison value otherwise.
    always @(posedge clk) begin
      pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem_read(g, bus.mem_addr) : 16'hDEAD;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign bus.mem_rdata = pipe[LAT-1];

    always @(negedge clk) begin
      if (reset) check("ack_exclusive", {31'd0, bus.ack0 & bus.ack1}, 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int d, input bit p, input bit r, input bit w,
                          input logic [15:0] a, input logic [15:0] wd);
    if (p) begin
      req1[d] = r; we1[d] = w; addr1[d] = a; wdata1[d] = wd;
    end else begin
      req0[d] = r; we0[d] = w; addr0[d] = a; wdata0[d] = wd;
    end
  endtask

  function automatic logic ack_of(input int d, input bit p);
    return p ? ack1[d] : ack0[d];
  endfunction

  task automatic check_zero(input int d);
    check("rst_ack0", ack0[d], 0);
    check("rst_ack1", ack1[d], 0);
    check("rst_rdata", rdata[d], 0);
    check("rst_busy", busy[d], 0);
    check("rst_owner", owner[d], 0);
    check("rst_mem_en", mem_en[d], 0);
    check("rst_mem_we", mem_we[d], 0);
    check("rst_mem_addr", mem_addr[d], 0);
    check("rst_mem_wdata", mem_wdata[d], 0);
  endtask

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      last_srv[d] = 1'b1;
      last_rd[d]  = 16'h0000;
    end
  endtask

  // One access from an idle arbiter; latency 2 for a store, RDLAT+2 for a load.
  task automatic single(input int d, input bit p, input bit w, input logic [15:0] a, input logic [15:0] wd);
    int exp_n;
    exp_n = w ? 2 : lat_of[d] + 2;
    set_port(d, p, 1'b1, w, a, wd);
    for (int n = 1; n <= exp_n; n++) begin
      step();
      check("mem_en", mem_en[d], (n == 1));
      if (n == 1) begin
        check("mem_we", mem_we[d], w);
        check("mem_addr", mem_addr[d], a);
        if (w) check("mem_wdata", mem_wdata[d], wd);
        check("owner", owner[d], p);
        check("busy", busy[d], 1);
      end
      check("ack_other", ack_of(d, !p), 0);
      check("ack", ack_of(d, p), (n == exp_n));
    end
    set_port(d, p, 1'b0, w, a, wd);
    if (w) mem_wr[{d[1:0], a}] = wd;
    else   last_rd[d] = mem_read(d, a);
    check("rdata", rdata[d], last_rd[d]);
    last_srv[d] = p;
    step();
    check("ack_after", ack_of(d, p), 0);
    check("busy_after", busy[d], 0);
  endtask

  // Port 0 holds req across acks, retargeting the address each time.
  task automatic b2b(input int d, input int cnt);
    logic [15:0] a;
    int gap;
    a = 16'($urandom);
    set_port(d, 1'b0, 1'b1, 1'b0, a, 16'h0);
    for (int i = 0; i < cnt; i++) begin
      gap = (i == 0) ? lat_of[d] + 2 : lat_of[d] + 3;
      for (int n = 1; n <= gap; n++) begin
        step();
        check("b2b_ack", ack0[d], (n == gap));
      end
      last_rd[d] = mem_read(d, a);
      check("b2b_rdata", rdata[d], last_rd[d]);
      a = 16'($urandom);
      set_port(d, 1'b0, (i != cnt - 1), 1'b0, a, 16'h0);
    end
    last_srv[d] = 1'b0;
    step();
    check("b2b_idle", busy[d], 0);
  endtask

  // Both ports request continuously: port 0 loads, port 1 stores.
  task automatic tie(input int d, input int cnt);
    logic [15:0] a0, a1, wd1;
    bit win;
    int gap;
    a0 = 16'($urandom);
    a1 = a0 ^ 16'h8000;
    wd1 = 16'($urandom);
    set_port(d, 1'b0, 1'b1, 1'b0, a0, 16'h0);
    set_port(d, 1'b1, 1'b1, 1'b1, a1, wd1);
    for (int i = 0; i < cnt; i++) begin
      win = !last_srv[d];
      gap = ((i == 0) ? 0 : 1) + (win ? 2 : lat_of[d] + 2);
      for (int n = 1; n <= gap; n++) begin
        step();
        check("tie_ack0", ack0[d], (n == gap) && !win);
        check("tie_ack1", ack1[d], (n == gap) && win);
      end
      if (win) mem_wr[{d[1:0], a1}] = wd1;
      else     last_rd[d] = mem_read(d, a0);
      check("tie_rdata", rdata[d], last_rd[d]);
      last_srv[d] = win;
      wd1 = 16'($urandom);
      set_port(d, 1'b0, (i != cnt - 1), 1'b0, a0, 16'h0);
      set_port(d, 1'b1, (i != cnt - 1), 1'b1, a1, wd1);
    end
    step();
    check("tie_idle", busy[d], 0);
  endtask

  // Request stays high two cycles past the ack, so exactly one more access follows.
  task automatic held(input int d);
    logic [15:0] a;
    int lat;
    lat = lat_of[d];
    a = 16'($urandom);
    set_port(d, 1'b0, 1'b1, 1'b0, a, 16'h0);
    for (int n = 1; n <= lat + 2; n++) begin
      step();
      check("held_ack1st", ack0[d], (n == lat + 2));
    end
    last_rd[d] = mem_read(d, a);
    check("held_rdata1", rdata[d], last_rd[d]);
    for (int m = 1; m <= lat + 3; m++) begin
      step();
      if (m == 3) set_port(d, 1'b0, 1'b0, 1'b0, a, 16'h0);
      check("held_mem_en", mem_en[d], (m == 2));
      if (m == 2) check("held_addr", mem_addr[d], a);
      check("held_ack2nd", ack0[d], (m == lat + 3));
    end
    check("held_rdata2", rdata[d], last_rd[d]);
    last_srv[d] = 1'b0;
    step();
    check("held_busy", busy[d], 0);
    step();
    check("held_no_third", mem_en[d], 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    int d;
    bit p, w;
    for (int i = 0; i < NDUT; i++) begin
      set_port(i, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      set_port(i, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    end
    model_reset();
    mem_wr[{2'd0, 16'h0010}] = 16'hBEEF;
    #1;
    for (int i = 0; i < NDUT; i++) check_zero(i);
    step();
    step();
    reset = 1'b1;
    step();

    single(0, 1'b0, 1'b0, 16'h0010, 16'h0000);
    single(0, 1'b1, 1'b1, 16'hFFFF, 16'h1234);
    tie(0, 4);
    b2b(0, 3);
    b2b(1, 3);
    b2b(3, 3);
    held(0);

    for (int i = 0; i < 16; i++) begin
      d = $urandom_range(0, NDUT - 1);
      p = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      single(d, p, w, a, 16'($urandom));
    end

    // Abort a port 1 load on the RDLAT=4 instance during its second WAIT cycle.
    a = 16'($urandom);
    set_port(2, 1'b1, 1'b1, 1'b0, a, 16'h0);
    for (int n = 1; n <= 3; n++) begin
      step();
      check("abort_mem_en", mem_en[2], (n == 1));
      check("abort_ack1", ack1[2], 0);
    end
    reset = 1'b0;
    set_port(2, 1'b1, 1'b0, 1'b0, a, 16'h0);
    #1;
    check_zero(2);
    model_reset();
    for (int n = 0; n < 3; n++) begin
      step();
      check("rst_hold_ack1", ack1[2], 0);
      check("rst_hold_mem_en", mem_en[2], 0);
    end
    reset = 1'b1;
    tie(2, 2);
    for (int n = 0; n < 8; n++) begin
      step();
      check("post_ack1", ack1[2], 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
